// File: rtl/xor_hash_pkg.sv
// Shared definitions for the multi-channel H3 hash front end: the default
// configuration, the beat layout and the reset pattern of the hash matrices.
package xor_hash_pkg;

    localparam int MAX_NUM_HASH    = 8;
    localparam int DEF_KEY_WIDTH   = 32;
    localparam int DEF_INDEX_WIDTH = 12;
    localparam int DEF_VALUE_WIDTH = 31;

    typedef struct packed {
        logic [DEF_KEY_WIDTH-1:0]   key;
        logic [DEF_VALUE_WIDTH-1:0] value;
        logic [1:0]                 opt;
    } hash_beat_t;

    // Reset contents of row i of hash h; callers truncate to the index width.
    function automatic logic [31:0] default_q(input int h, input int i);
        return 32'((i + 1) * (2 * h + 3));
    endfunction

endpackage

// File: rtl/xor_hash_lane.sv
// One H3 hash channel: a programmable row bank plus the two half-key XOR trees
// whose results the top registers in its first pipeline stage.
module xor_hash_lane
    import xor_hash_pkg::*;
#(
    parameter int KEY_WIDTH   = DEF_KEY_WIDTH,
    parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
    parameter int HASH_ID     = 0,
    parameter int ROW_W       = $clog2(KEY_WIDTH),
    parameter int HASH_SEL_W  = $clog2(MAX_NUM_HASH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_we_ok,
    input  logic [HASH_SEL_W-1:0]  cfg_hash,
    input  logic [ROW_W-1:0]       cfg_row,
    input  logic [INDEX_WIDTH-1:0] cfg_data,
    input  logic [KEY_WIDTH-1:0]   key,
    output logic [INDEX_WIDTH-1:0] part_lo,
    output logic [INDEX_WIDTH-1:0] part_hi
);

    localparam int HALF = KEY_WIDTH / 2;

    logic [INDEX_WIDTH-1:0] q_q [KEY_WIDTH];
    logic [INDEX_WIDTH-1:0] q_d [KEY_WIDTH];
    logic                   wr_hit;

    assign wr_hit = cfg_we_ok && (cfg_hash == HASH_SEL_W'(HASH_ID));

    always_comb begin
        q_d = q_q;
        if (wr_hit) begin
            q_d[cfg_row] = cfg_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < KEY_WIDTH; i++) begin
                q_q[i] <= INDEX_WIDTH'(default_q(HASH_ID, i));
            end
        end else begin
            q_q <= q_d;
        end
    end

    // Reads see the pre-write rows, so a beat accepted alongside a write uses old Q.
    always_comb begin
        part_lo = '0;
        part_hi = '0;
        for (int i = 0; i < HALF; i++) begin
            if (key[i]) part_lo = part_lo ^ q_q[i];
        end
        for (int i = HALF; i < KEY_WIDTH; i++) begin
            if (key[i]) part_hi = part_hi ^ q_q[i];
        end
    end

endmodule

// File: rtl/xor_hash_multi.sv
// NUM_HASH parallel H3 hashes of one key in a 2-stage valid/ready pipeline that
// carries key, value and opt alongside the indices.
module xor_hash_multi
    import xor_hash_pkg::*;
#(
    parameter int KEY_WIDTH   = DEF_KEY_WIDTH,
    parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
    parameter int VALUE_WIDTH = DEF_VALUE_WIDTH,
    parameter int NUM_HASH    = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [KEY_WIDTH-1:0]            key,
    input  logic [VALUE_WIDTH-1:0]          value_in,
    input  logic [1:0]                      opt_in,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_HASH*INDEX_WIDTH-1:0] index,
    output logic [KEY_WIDTH-1:0]            key_out,
    output logic [VALUE_WIDTH-1:0]          value_out,
    output logic [1:0]                      opt_out,
    input  logic                            cfg_we,
    input  logic [2:0]                      cfg_hash,
    input  logic [$clog2(KEY_WIDTH)-1:0]    cfg_row,
    input  logic [INDEX_WIDTH-1:0]          cfg_data,
    output logic                            cfg_err
);

    localparam int ROW_W      = $clog2(KEY_WIDTH);
    localparam int HASH_SEL_W = $clog2(MAX_NUM_HASH);
    localparam int IDX_ALL_W  = NUM_HASH * INDEX_WIDTH;

    // Valid/ready: a beat moves on any edge where valid and ready are both high;
    // a stage advances when it is empty or its successor advances, and in_ready
    // depends only on stage occupancy and out_ready, never on in_valid.
    typedef struct packed {
        logic [KEY_WIDTH-1:0]   key;
        logic [VALUE_WIDTH-1:0] value;
        logic [1:0]             opt;
    } beat_t;

    logic                 s1_valid_q, s1_valid_d;
    logic                 s2_valid_q, s2_valid_d;
    beat_t                s1_beat_q, s1_beat_d;
    beat_t                s2_beat_q, s2_beat_d;
    logic [IDX_ALL_W-1:0] s1_lo_q, s1_lo_d;
    logic [IDX_ALL_W-1:0] s1_hi_q, s1_hi_d;
    logic [IDX_ALL_W-1:0] index_q, index_d;
    logic                 cfg_err_q, cfg_err_d;

    logic [IDX_ALL_W-1:0] lo_all;
    logic [IDX_ALL_W-1:0] hi_all;
    logic                 s1_adv;
    logic                 s2_adv;
    logic                 cfg_ok;

    assign cfg_ok = ({1'b0, cfg_hash} < 4'(NUM_HASH)) &&
                    ({1'b0, cfg_row} < (ROW_W + 1)'(KEY_WIDTH));

    for (genvar h = 0; h < NUM_HASH; h++) begin : g_lane
        xor_hash_lane #(
            .KEY_WIDTH  (KEY_WIDTH),
            .INDEX_WIDTH(INDEX_WIDTH),
            .HASH_ID    (h),
            .ROW_W      (ROW_W),
            .HASH_SEL_W (HASH_SEL_W)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .cfg_we_ok(cfg_we && cfg_ok),
            .cfg_hash (cfg_hash),
            .cfg_row  (cfg_row),
            .cfg_data (cfg_data),
            .key      (key),
            .part_lo  (lo_all[h*INDEX_WIDTH +: INDEX_WIDTH]),
            .part_hi  (hi_all[h*INDEX_WIDTH +: INDEX_WIDTH])
        );
    end

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_beat_d  = s1_beat_q;
        s1_lo_d    = s1_lo_q;
        s1_hi_d    = s1_hi_q;
        s2_valid_d = s2_valid_q;
        s2_beat_d  = s2_beat_q;
        index_d    = index_q;
        cfg_err_d  = cfg_we && !cfg_ok;

        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_beat_d = '{key: key, value: value_in, opt: opt_in};
                s1_lo_d   = lo_all;
                s1_hi_d   = hi_all;
            end
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_beat_d = s1_beat_q;
                index_d   = s1_lo_q ^ s1_hi_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_beat_q  <= '0;
            s1_lo_q    <= '0;
            s1_hi_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_beat_q  <= '0;
            index_q    <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_beat_q  <= s1_beat_d;
            s1_lo_q    <= s1_lo_d;
            s1_hi_q    <= s1_hi_d;
            s2_valid_q <= s2_valid_d;
            s2_beat_q  <= s2_beat_d;
            index_q    <= index_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign index     = index_q;
    assign key_out   = s2_beat_q.key;
    assign value_out = s2_beat_q.value;
    assign opt_out   = s2_beat_q.opt;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_xor_hash_multi.sv
// Directed bench for xor_hash_multi: driver tasks push hand-computed results
// into a queue that an independent output monitor pops and compares.
module tb_xor_hash_multi;
    import xor_hash_pkg::*;

    localparam int KW  = 32;
    localparam int IW  = 12;
    localparam int VW  = 31;
    localparam int NH  = 2;
    localparam int EXP_W = NH * IW + $bits(hash_beat_t);

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [KW-1:0]   key;
    logic [VW-1:0]   value_in;
    logic [1:0]      opt_in;
    logic            out_valid;
    logic            out_ready;
    logic [NH*IW-1:0] index;
    logic [KW-1:0]   key_out;
    logic [VW-1:0]   value_out;
    logic [1:0]      opt_out;
    logic            cfg_we;
    logic [2:0]      cfg_hash;
    logic [4:0]      cfg_row;
    logic [IW-1:0]   cfg_data;
    logic            cfg_err;

    logic [EXP_W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;
    logic saw_ready_low = 1'b0;

    xor_hash_multi #(
        .KEY_WIDTH(KW), .INDEX_WIDTH(IW), .VALUE_WIDTH(VW), .NUM_HASH(NH)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .key(key), .value_in(value_in), .opt_in(opt_in),
        .out_valid(out_valid), .out_ready(out_ready), .index(index),
        .key_out(key_out), .value_out(value_out), .opt_out(opt_out),
        .cfg_we(cfg_we), .cfg_hash(cfg_hash), .cfg_row(cfg_row),
        .cfg_data(cfg_data), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Present one beat and hold it until accepted; the expected output is queued at accept.
    task automatic send(input logic [KW-1:0] k, input logic [VW-1:0] v, input logic [1:0] o,
                        input logic [IW-1:0] h0, input logic [IW-1:0] h1);
        hash_beat_t b;
        int n = 0;
        in_valid = 1'b1;
        key      = k;
        value_in = v;
        opt_in   = o;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 100) begin
                checks++;
                failures++;
                $display("FAIL send_timeout key=%0h never accepted", k);
                return;
            end
        end
        b = '{key: k, value: v, opt: o};
        exp_q.push_back({h1, h0, b});
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        while (exp_q.size() != 0 || out_valid) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 100) begin
                checks++;
                failures++;
                $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
                exp_q.delete();
                break;
            end
        end
    endtask

    // Output monitor: pops on every accepted beat and checks hold-while-stalled.
    initial begin
        logic [EXP_W-1:0] now_v, held, e;
        logic held_v = 1'b0;
        forever begin
            @(negedge clk);
            now_v = {index, key_out, value_out, opt_out};
            if (reset !== 1'b1) begin
                held_v = 1'b0;
                continue;
            end
            if (held_v) begin
                checks++;
                if (!out_valid || now_v !== held) begin
                    failures++;
                    $display("FAIL stall_hold actual=%0h/%0b required=%0h/1", now_v, out_valid, held);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat actual=%0h required=none", now_v);
                end else begin
                    e = exp_q.pop_front();
                    if (now_v !== e) begin
                        failures++;
                        $display("FAIL beat actual=%0h required=%0h", now_v, e);
                    end
                end
            end
            if (!out_ready && !in_ready) saw_ready_low = 1'b1;
            held_v = out_valid && !out_ready;
            held   = now_v;
        end
    end

    initial begin
        reset = 1'b0; in_valid = 1'b0; key = '0; value_in = '0; opt_in = '0;
        out_ready = 1'b1; cfg_we = 1'b0; cfg_hash = '0; cfg_row = '0; cfg_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_index", 128'(index), 128'(0));
        check("rst_cfg_err", 128'(cfg_err), 128'(0));
        reset = 1'b1;
        #1;
        check("in_ready_after_reset", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1;

        // Key 0 hashes to 0 in every channel.
        send(32'h0000_0000, 31'h0000_0042, 2'd0, 12'h000, 12'h000);
        drain();

        // Back-to-back beats: rows 0 and 31 of the default matrices.
        send(32'h0000_0001, 31'h0000_1234, 2'd1, 12'h003, 12'h005);
        send(32'h8000_0000, 31'h7fff_ffff, 2'd2, 12'h060, 12'h0A0);
        send(32'h8000_0001, 31'h0000_0000, 2'd3, 12'h063, 12'h0A5);
        in_valid = 1'b0;
        check("b2b_second_latency", 128'(key_out), 128'(32'h8000_0000));
        @(posedge clk);
        #1;
        check("b2b_third_latency", 128'(key_out), 128'(32'h8000_0001));
        drain();

        // Write h0 row0 while accepting key=1: that beat sees the old row.
        cfg_we = 1'b1; cfg_hash = 3'd0; cfg_row = 5'd0; cfg_data = 12'hABC;
        send(32'h0000_0001, 31'h0000_0011, 2'd0, 12'h003, 12'h005);
        cfg_we = 1'b0;
        send(32'h0000_0001, 31'h0000_0022, 2'd1, 12'hABC, 12'h005);
        drain();

        // Out-of-range hash number is ignored and flagged one cycle later.
        cfg_we = 1'b1; cfg_hash = 3'd2; cfg_row = 5'd0; cfg_data = 12'hFFF;
        @(negedge clk);
        check("cfg_err_same_cycle", 128'(cfg_err), 128'(0));
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        check("cfg_err_pulse", 128'(cfg_err), 128'(1));
        @(posedge clk);
        #1;
        check("cfg_err_clears", 128'(cfg_err), 128'(0));
        send(32'h0000_0001, 31'h0000_0033, 2'd2, 12'hABC, 12'h005);
        drain();

        // Six single-bit keys with a 3-cycle downstream stall mid-stream.
        fork
            begin
                send(32'h0000_0002, 31'h0000_0001, 2'd0, 12'h006, 12'h00A);
                send(32'h0000_0004, 31'h0000_0002, 2'd1, 12'h009, 12'h00F);
                send(32'h0000_0008, 31'h0000_0003, 2'd2, 12'h00C, 12'h014);
                send(32'h0000_0010, 31'h0000_0004, 2'd3, 12'h00F, 12'h019);
                send(32'h0000_0020, 31'h0000_0005, 2'd0, 12'h012, 12'h01E);
                send(32'h0000_0040, 31'h0000_0006, 2'd1, 12'h015, 12'h023);
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("in_ready_dropped_when_full", 128'(saw_ready_low), 128'(1));

        // Reset with two beats in flight: both are dropped, matrices restored.
        send(32'h0000_0002, 31'h0000_0077, 2'd0, 12'h006, 12'h00A);
        send(32'h0000_0004, 31'h0000_0078, 2'd1, 12'h009, 12'h00F);
        in_valid = 1'b0;
        check("inflight_before_reset", 128'(out_valid), 128'(1));
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("reset_out_valid", 128'(out_valid), 128'(0));
        check("reset_index", 128'(index), 128'(0));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("in_ready_after_midreset", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1;
        send(32'h0000_0001, 31'h0000_0055, 2'd3, 12'h003, 12'h005);
        drain();
        repeat (5) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
